// File: rtl/rgb_pkg.sv
// ============================================================================
// Module   : rgb_pkg
// Purpose  : Shared colour constants, fill-colour palette and default
//            screen geometry for the bouncing-box pattern generator.
// Contents : 3-bit {R,G,B} colour constants, 4-entry PALETTE, active-area
//            defaults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rgb_pkg;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  // Packed so entry 0 sits in the low bits: idx 0 CYAN, 1 RED, 2 GREEN, 3 BLUE.
  localparam logic [3:0][2:0] PALETTE = {BLUE, GREEN, RED, CYAN};

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

endpackage : rgb_pkg

`default_nettype wire

// File: rtl/rgb_bounce_axis.sv
// ============================================================================
// Module   : rgb_bounce_axis
// Purpose  : Position/direction state of the box along one screen axis.
//            Each update moves the box STEP px; when the move would leave
//            the screen the box is clamped to the edge and direction flips.
// Ports    : clk_i, rst_ni (async, active low), update (apply one move),
//            pos (current leading edge, px), bounce (the pending move flips
//            direction; meaningful whenever update is asserted).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_bounce_axis #(
  parameter int SIZE  = 240,
  parameter int LIMIT = 640,
  parameter int START = 40,
  parameter int STEP  = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       update,
  output logic [9:0] pos,
  output logic       bounce
);

  localparam logic [10:0] SIZE_C  = 11'(SIZE);
  localparam logic [10:0] LIMIT_C = 11'(LIMIT);
  localparam logic [10:0] STEP_C  = 11'(STEP);
  localparam logic [9:0]  STEP_P  = 10'(STEP);
  localparam logic [9:0]  MAX_POS = 10'(LIMIT - SIZE);
  localparam logic [9:0]  START_P = 10'(START);

  logic        dir;        // 0: increasing (right/down), 1: decreasing
  logic [10:0] pos_ext;
  logic [10:0] far_edge;   // trailing edge after a forward move, 11 bits so it never wraps
  logic [9:0]  pos_next;

  always_comb begin
    pos_ext  = {1'b0, pos};
    far_edge = pos_ext + SIZE_C + STEP_C;
    bounce   = dir ? (pos_ext < STEP_C) : (far_edge > LIMIT_C);
    pos_next = pos;
    if (dir) begin
      pos_next = bounce ? 10'd0 : (pos - STEP_P);
    end else begin
      pos_next = bounce ? MAX_POS : (pos + STEP_P);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos <= START_P;
      dir <= 1'b0;
    end else if (update) begin
      pos <= pos_next;
      if (bounce) begin
        dir <= ~dir;
      end
    end
  end

endmodule : rgb_bounce_axis

`default_nettype wire

// File: rtl/rgb_box_bounce.sv
// ============================================================================
// Module   : rgb_box_bounce
// Purpose  : VGA pattern generator drawing a solid box on a background that
//            moves STEP px per frame and bounces off the screen edges. The
//            fill colour steps through a 4-entry palette on every bounce.
// Ports    : clk_i pixel clock; rst_ni async active-low reset; en_i active
//            video; column_i/row_i pixel coordinate; frame_i start-of-vblank
//            pulse; pause_i freezes motion; rgb_o registered {R,G,B};
//            bounce_cnt_o wrapping bounce count; corner_o double-bounce pulse.
// Config   : `define RGB_BOX_BORDER_EN draws a BORDER_W px white frame just
//            inside the box edges; otherwise the whole box is palette colour.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_box_bounce
  import rgb_pkg::*;
#(
  parameter int         H_ACTIVE = H_ACTIVE_DEF,
  parameter int         V_ACTIVE = V_ACTIVE_DEF,
  parameter int         BOX_W    = 240,
  parameter int         BOX_H    = 240,
  parameter int         X0       = 40,
  parameter int         Y0       = 120,
  parameter int         STEP     = 4,
  parameter logic [2:0] BG_COLOR = MAGENTA,
  parameter int         BORDER_W = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [9:0] column_i,
  input  logic [9:0] row_i,
  input  logic       frame_i,
  input  logic       pause_i,
  output logic [2:0] rgb_o,
  output logic [7:0] bounce_cnt_o,
  output logic       corner_o
);

  // Illegal geometry is rejected while elaborating rather than drawing garbage.
  if (H_ACTIVE < 1 || H_ACTIVE > 1024 || V_ACTIVE < 1 || V_ACTIVE > 1024) begin : g_bad_screen
    $error("rgb_box_bounce: H_ACTIVE/V_ACTIVE must be 1..1024");
  end
  if (BOX_W < 1 || BOX_W > H_ACTIVE || BOX_H < 1 || BOX_H > V_ACTIVE) begin : g_bad_box
    $error("rgb_box_bounce: box size does not fit the screen");
  end
  if (X0 < 0 || Y0 < 0 || X0 + BOX_W > H_ACTIVE || Y0 + BOX_H > V_ACTIVE) begin : g_bad_start
    $error("rgb_box_bounce: start position places box off screen");
  end
  if (STEP < 1 || STEP > 63) begin : g_bad_step
    $error("rgb_box_bounce: STEP must be 1..63");
  end
  if (BORDER_W < 1) begin : g_bad_border
    $error("rgb_box_bounce: BORDER_W must be at least 1");
  end

  logic [9:0] pos_x, pos_y;
  logic       bounce_x, bounce_y;
  logic       update;
  logic [1:0] pal_idx;
  logic [2:0] rgb_next;
  logic       in_box;

  assign update = frame_i & ~pause_i;

  rgb_bounce_axis #(
    .SIZE(BOX_W), .LIMIT(H_ACTIVE), .START(X0), .STEP(STEP)
  ) u_axis_x (
    .clk_i(clk_i), .rst_ni(rst_ni), .update(update), .pos(pos_x), .bounce(bounce_x)
  );

  rgb_bounce_axis #(
    .SIZE(BOX_H), .LIMIT(V_ACTIVE), .START(Y0), .STEP(STEP)
  ) u_axis_y (
    .clk_i(clk_i), .rst_ni(rst_ni), .update(update), .pos(pos_y), .bounce(bounce_y)
  );

  // Hit test in 12 bits so box edges near the right/bottom never wrap.
  logic [11:0] col_w, row_w, x_lo, x_hi, y_lo, y_hi;
  assign col_w = {2'b00, column_i};
  assign row_w = {2'b00, row_i};
  assign x_lo  = {2'b00, pos_x};
  assign y_lo  = {2'b00, pos_y};
  assign x_hi  = x_lo + 12'(BOX_W - 1);
  assign y_hi  = y_lo + 12'(BOX_H - 1);
  assign in_box = (col_w >= x_lo) && (col_w <= x_hi) &&
                  (row_w >= y_lo) && (row_w <= y_hi);

`ifdef RGB_BOX_BORDER_EN
  localparam logic [11:0] BW_C = 12'(BORDER_W);
  logic on_border;
  // Pixel is within BORDER_W of an edge when it is closer than BORDER_W to
  // the low edge, or adding BORDER_W carries it past the high edge.
  assign on_border = (col_w < x_lo + BW_C) || (col_w + BW_C > x_hi) ||
                     (row_w < y_lo + BW_C) || (row_w + BW_C > y_hi);
`endif

  always_comb begin
    rgb_next = BLACK;
    if (en_i) begin
      if (in_box) begin
        rgb_next = PALETTE[pal_idx];
`ifdef RGB_BOX_BORDER_EN
        if (on_border) begin
          rgb_next = WHITE;
        end
`endif
      end else begin
        rgb_next = BG_COLOR;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rgb_o        <= BLACK;
      pal_idx      <= 2'd0;
      bounce_cnt_o <= 8'd0;
      corner_o     <= 1'b0;
    end else begin
      rgb_o    <= rgb_next;
      // A simultaneous double flip is still one bounce event.
      corner_o <= update & bounce_x & bounce_y;
      if (update && (bounce_x || bounce_y)) begin
        pal_idx      <= pal_idx + 2'd1;
        bounce_cnt_o <= bounce_cnt_o + 8'd1;
      end
    end
  end

endmodule : rgb_box_bounce

`default_nettype wire

// File: tb/tb_rgb_box_bounce.sv
// ============================================================================
// Module   : tb_rgb_box_bounce
// Purpose  : Self-checking bench for rgb_box_bounce. A behavioural model of
//            the box (integer position, direction, palette index) predicts
//            every output each cycle; directed pixel probes with literal
//            colours pin both the DUT and the model. A second instance
//            started in the bottom-right corner exercises the double bounce.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb_box_bounce;

  localparam int BW = 240, BH = 240, HA = 640, VA = 480, ST = 4;
`ifdef RGB_BOX_BORDER_EN
  localparam bit BRD = 1'b1;
`else
  localparam bit BRD = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [9:0] col, row;
  logic       frame, frame_c, pause;
  logic [2:0] rgb, rgb_c;
  logic [7:0] cnt, cnt_c;
  logic       corner, corner_c;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  rgb_box_bounce u_dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .column_i(col), .row_i(row),
    .frame_i(frame), .pause_i(pause), .rgb_o(rgb), .bounce_cnt_o(cnt), .corner_o(corner)
  );

  rgb_box_bounce #(.X0(400), .Y0(240)) u_corner (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .column_i(col), .row_i(row),
    .frame_i(frame_c), .pause_i(pause), .rgb_o(rgb_c), .bounce_cnt_o(cnt_c), .corner_o(corner_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [2:0] pal [4] = '{3'b011, 3'b100, 3'b010, 3'b001};
  int m_x, m_y, m_dx, m_dy, m_idx, m_cnt;   // m_d*: 0 = increasing, 1 = decreasing
  logic [2:0] m_rgb;
  bit m_corner;

  function automatic bit ax_flip(int p, int d, int sz, int lim);
    if (d != 0) return p < ST;
    return (p + sz + ST) > lim;
  endfunction

  function automatic int ax_next(int p, int d, int sz, int lim);
    if (ax_flip(p, d, sz, lim)) return (d != 0) ? 0 : lim - sz;
    return (d != 0) ? p - ST : p + ST;
  endfunction

  function automatic logic [2:0] m_pixel(logic e, int c, int r);
    if (!e) return 3'b000;
    if (c >= m_x && c < m_x + BW && r >= m_y && r < m_y + BH) begin
      if (BRD && (c < m_x + 4 || c >= m_x + BW - 4 || r < m_y + 4 || r >= m_y + BH - 4))
        return 3'b111;
      return pal[m_idx];
    end
    return 3'b101;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_x <= 40; m_y <= 120; m_dx <= 0; m_dy <= 0;
      m_idx <= 0; m_cnt <= 0; m_rgb <= 3'b000; m_corner <= 1'b0;
    end else begin
      m_rgb    <= m_pixel(en, int'(col), int'(row));
      m_corner <= 1'b0;
      if (frame && !pause) begin
        m_x  <= ax_next(m_x, m_dx, BW, HA);
        m_y  <= ax_next(m_y, m_dy, BH, VA);
        m_dx <= m_dx ^ int'(ax_flip(m_x, m_dx, BW, HA));
        m_dy <= m_dy ^ int'(ax_flip(m_y, m_dy, BH, VA));
        if (ax_flip(m_x, m_dx, BW, HA) || ax_flip(m_y, m_dy, BH, VA)) begin
          m_cnt <= (m_cnt + 1) % 256;
          m_idx <= (m_idx + 1) % 4;
        end
        m_corner <= ax_flip(m_x, m_dx, BW, HA) && ax_flip(m_y, m_dy, BH, VA);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("cmp_rgb", 32'(rgb), 32'(m_rgb));
      check("cmp_cnt", 32'(cnt), 32'(m_cnt));
      check("cmp_corner", 32'(corner), 32'(m_corner));
    end
  end

  function automatic logic [2:0] edge_c(logic [2:0] c);
    return BRD ? 3'b111 : c;
  endfunction

  // All tasks start and end at posedge+1.
  task automatic pix(input string nm, input logic e, input int c, input int r, input logic [2:0] exp);
    en = e; col = c[9:0]; row = r[9:0]; frame = 1'b0;
    @(posedge clk); #1;
    check(nm, 32'(rgb), 32'(exp));
  endtask

  task automatic do_frame(input logic p);
    en = 1'($urandom_range(0, 1)); col = 10'($urandom_range(0, 639)); row = 10'($urandom_range(0, 479));
    frame = 1'b1; pause = p;
    @(posedge clk); #1;
    frame = 1'b0; pause = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en = 1'b1; col = 10'($urandom_range(0, 639)); row = 10'($urandom_range(0, 479));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; col = '0; row = '0; frame = 1'b0; frame_c = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", 32'(rgb), 32'd0);
    check("reset_cnt", 32'(cnt), 32'd0);
    check("reset_corner", 32'(corner), 32'd0);
    rst_n = 1'b1; chk_on = 1'b1;

    // Static box at (40,120)
    pix("first_pixel", 1'b1, 100, 200, 3'b011);
    check("model_first", 32'(m_rgb), 32'(3'b011));
    pix("left_in", 1'b1, 40, 200, edge_c(3'b011));
    pix("left_out", 1'b1, 39, 200, 3'b101);
    pix("right_in", 1'b1, 279, 200, edge_c(3'b011));
    pix("right_out", 1'b1, 280, 200, 3'b101);
    pix("top_out", 1'b1, 100, 119, 3'b101);
    pix("top_in", 1'b1, 100, 120, edge_c(3'b011));
    pix("bot_in", 1'b1, 100, 359, edge_c(3'b011));
    pix("bot_out", 1'b1, 100, 360, 3'b101);
    pix("blank", 1'b0, 100, 200, 3'b000);
    pix("border_42", 1'b1, 42, 200, edge_c(3'b011));
    pix("inner_44", 1'b1, 44, 200, 3'b011);

    // One move then a paused frame
    for (int p = 0; p < 2; p++) begin
      do_frame(p[0]);
      pix("mv_col43", 1'b1, 43, 200, 3'b101);
      pix("mv_col44", 1'b1, 44, 200, edge_c(3'b011));
      pix("mv_row123", 1'b1, 50, 123, 3'b101);
      pix("mv_row124", 1'b1, 50, 124, edge_c(3'b011));
      check("model_x44", 32'(m_x), 32'd44);
    end

    // Frames 2..31: vertical bounce on frame 31
    for (int f = 2; f <= 31; f++) do_frame(1'b0);
    check("f31_cnt", 32'(cnt), 32'd1);
    check("f31_model_y", 32'(m_y), 32'd240);
    pix("f31_in", 1'b1, 170, 300, 3'b100);
    pix("f31_out", 1'b1, 163, 300, 3'b101);

    // Frames 32..91: horizontal bounce on frame 91
    for (int f = 32; f <= 91; f++) do_frame(1'b0);
    check("f91_cnt", 32'(cnt), 32'd2);
    check("f91_model_x", 32'(m_x), 32'd400);
    check("f91_model_dx", 32'(m_dx), 32'd1);
    pix("f91_in", 1'b1, 410, 10, 3'b010);
    pix("f91_out", 1'b1, 399, 10, 3'b101);

    do_frame(1'b0);
    check("f92_cnt", 32'(cnt), 32'd3);
    check("f92_model_x", 32'(m_x), 32'd396);
    pix("f92_in", 1'b1, 400, 10, 3'b001);
    pix("f92_out_l", 1'b1, 395, 10, 3'b101);
    pix("f92_edge_r", 1'b1, 635, 10, edge_c(3'b001));
    pix("f92_out_r", 1'b1, 636, 10, 3'b101);

    // Asynchronous reset in the middle of a line
    en = 1'b1; col = 10'd300; row = 10'd200;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rgb", 32'(rgb), 32'd0);
    check("mid_rst_cnt", 32'(cnt), 32'd0);
    check("mid_rst_corner", 32'(corner), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_rel_rgb", 32'(rgb), 32'd0);
    pix("post_rst", 1'b1, 100, 200, 3'b011);

    // Corner instance: both axes flip on the first frame
    en = 1'b1; col = 10'd450; row = 10'd300; frame_c = 1'b1;
    @(posedge clk); #1;
    frame_c = 1'b0;
    check("cr_corner_hi", 32'(corner_c), 32'd1);
    check("cr_cnt", 32'(cnt_c), 32'd1);
    check("cr_old_colour", 32'(rgb_c), 32'(3'b011));
    @(posedge clk); #1;
    check("cr_corner_lo", 32'(corner_c), 32'd0);
    check("cr_new_colour", 32'(rgb_c), 32'(3'b100));
    col = 10'd399;
    @(posedge clk); #1;
    check("cr_left_out", 32'(rgb_c), 32'(3'b101));
    col = 10'd400; row = 10'd240;
    @(posedge clk); #1;
    check("cr_origin", 32'(rgb_c), 32'(edge_c(3'b100)));
    check("cr_cnt_hold", 32'(cnt_c), 32'd1);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_rgb_box_bounce

`default_nettype wire
